// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with parking on DEFAULT_MASTER; grants move only on hready=1.
// Optional master locking (hlock/hmastlock) is compiled in when ARB_HLOCK_EN is defined.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int HOLD_MAX       = 16,
  parameter int MW             = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  input  logic [1:0]             hresp,
`ifdef ARB_HLOCK_EN
  input  logic [NUM_MASTERS-1:0] hlock,
  output logic                   hmastlock,
`endif
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_d
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [MW-1:0] DEF_IDX  = MW'(DEFAULT_MASTER);

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_SEQ  = 2'b11;
  localparam logic [1:0] RS_RETRY = 2'b10;
  localparam logic [1:0] RS_SPLIT = 2'b11;

  // Arbiter state is named so checkers can bind to it hierarchically.
  typedef enum logic {PARK = 1'b0, OWN = 1'b1} state_t;
  state_t state;

  logic [HW-1:0]          hold_cnt;
  logic [NUM_MASTERS-1:0] own_mask;
  logic                   owner_req, others_req, locked;
  logic                   ap_idle, ap_drop, ap_hold, ap_retry, ap;
  logic                   excl_owner, win_found;
  logic [MW-1:0]          win_idx, next_owner;
  logic [NUM_MASTERS-1:0] next_grant;
  int                     best;

  always_comb begin
    own_mask = '0;
    for (int i = 0; i < NUM_MASTERS; i++) own_mask[i] = (MW'(i) == hmaster);
  end

  assign owner_req  = |(hbusreq & own_mask);
  assign others_req = |(hbusreq & ~own_mask);
`ifdef ARB_HLOCK_EN
  assign locked = |(hlock & own_mask);
`else
  assign locked = 1'b0;
`endif

  // RETRY/SPLIT is only acted on in its second (hready=1) cycle and overrides locking.
  assign ap_idle  = (htrans == TR_IDLE) && !locked;
  assign ap_drop  = !owner_req && !locked;
  assign ap_hold  = (hold_cnt >= HOLD_LIM) && (htrans != TR_SEQ) && !locked;
  assign ap_retry = (hresp == RS_RETRY) || (hresp == RS_SPLIT);
  assign ap       = hready && (ap_idle || ap_drop || ap_hold || ap_retry);
  assign excl_owner = ap_retry && others_req;

  // Rank 1 is the master just after the owner; the owner itself ranks last.
  always_comb begin
    best    = NUM_MASTERS + 1;
    win_idx = DEF_IDX;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      int rank;
      rank = (i + NUM_MASTERS - int'(hmaster)) % NUM_MASTERS;
      if (rank == 0) rank = NUM_MASTERS;
      if (hbusreq[i] && !(own_mask[i] && excl_owner) && (rank < best)) begin
        best    = rank;
        win_idx = MW'(i);
      end
    end
  end

  assign win_found  = (best <= NUM_MASTERS);
  assign next_owner = !ap ? hmaster : (win_found ? win_idx : DEF_IDX);

  always_comb begin
    next_grant = '0;
    for (int i = 0; i < NUM_MASTERS; i++) next_grant[i] = (MW'(i) == next_owner);
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= PARK;
      hold_cnt  <= '0;
      hmaster   <= DEF_IDX;
      hmaster_d <= DEF_IDX;
      hgrant    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
`ifdef ARB_HLOCK_EN
      hmastlock <= 1'b0;
`endif
    end else if (hready) begin
      hmaster_d <= hmaster;
`ifdef ARB_HLOCK_EN
      hmastlock <= locked;
`endif
      if (ap) begin
        state   <= win_found ? OWN : PARK;
        hmaster <= next_owner;
        hgrant  <= next_grant;
      end
      if (next_owner != hmaster) begin
        hold_cnt <= '0;
      end else if ((state == OWN) && others_req && (hold_cnt < HOLD_LIM)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (2 masters, HOLD_MAX=4); a driver queues expected
// {hgrant,hmaster,hmaster_d} per edge and a monitor pops and compares after each edge.
module tb_ahb_arbiter;

  localparam int N  = 2;
  localparam int MW = 1;
  localparam int W  = N + 2 * MW;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, ERR = 2'b01, RETRY = 2'b10;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [N-1:0]  hbusreq;
  logic [1:0]    htrans;
  logic          hready;
  logic [1:0]    hresp;
  logic [N-1:0]  hgrant;
  logic [MW-1:0] hmaster, hmaster_d;
`ifdef ARB_HLOCK_EN
  logic [N-1:0]  hlock;
  logic          hmastlock;
`endif

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .HOLD_MAX(4), .MW(MW)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .htrans(htrans),
    .hready(hready), .hresp(hresp),
`ifdef ARB_HLOCK_EN
    .hlock(hlock), .hmastlock(hmastlock),
`endif
    .hgrant(hgrant), .hmaster(hmaster), .hmaster_d(hmaster_d)
  );

  // Clock / reset
  always #5 hclk = ~hclk;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  always @(posedge hclk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if ({hgrant, hmaster, hmaster_d} !== e) begin
        n_bad++;
        $display("FAIL %s: got grant=%b master=%0d master_d=%0d, want grant=%b master=%0d master_d=%0d",
                 nm, hgrant, hmaster, hmaster_d, e[W-1 -: N], e[2*MW-1 -: MW], e[MW-1:0]);
      end
    end
  end

  // Driver: apply inputs at negedge, queue the outputs expected after the next posedge.
  task automatic step(input logic rstn, input logic [N-1:0] req, input logic [1:0] trans,
                      input logic rdy, input logic [1:0] resp, input logic [N-1:0] eg,
                      input logic [MW-1:0] em, input logic [MW-1:0] emd, input string nm);
    @(negedge hclk);
    hresetn = rstn;
    hbusreq = req;
    htrans  = trans;
    hready  = rdy;
    hresp   = resp;
    exp_q.push_back({eg, em, emd});
    name_q.push_back(nm);
  endtask

  initial begin
    hresetn = 1'b0; hbusreq = '0; htrans = IDLE; hready = 1'b1; hresp = OKAY;
`ifdef ARB_HLOCK_EN
    hlock = '0;
`endif
    // Reset and parking
    step(0, 2'b11, SEQ,  1, OKAY, 2'b01, 0, 0, "reset_a");
    step(0, 2'b00, IDLE, 1, OKAY, 2'b01, 0, 0, "reset_b");
    for (int i = 0; i < 10; i++) step(1, 2'b00, IDLE, 1, OKAY, 2'b01, 0, 0, "park");
    // M1 request from park, then hmaster_d follows one hready cycle later
    step(1, 2'b10, IDLE, 1, OKAY, 2'b10, 1, 0, "grant_m1");
    step(1, 2'b10, NSEQ, 1, OKAY, 2'b10, 1, 1, "m1_data_phase");
    // RETRY while M1 owns: first cycle waits, second cycle hands over to M0
    step(1, 2'b11, NSEQ, 1, OKAY,  2'b10, 1, 1, "m1_hold");
    step(1, 2'b11, SEQ,  0, RETRY, 2'b10, 1, 1, "retry_cycle1");
    step(1, 2'b11, SEQ,  1, RETRY, 2'b01, 0, 1, "retry_cycle2");
    // M0 burst with M1 waiting: no switch on SEQ, switch on NONSEQ once hold limit reached
    step(1, 2'b11, NSEQ, 1, OKAY, 2'b01, 0, 0, "burst_nseq");
    step(1, 2'b11, SEQ,  1, OKAY, 2'b01, 0, 0, "burst_seq1");
    step(1, 2'b11, SEQ,  1, OKAY, 2'b01, 0, 0, "burst_seq2");
    step(1, 2'b11, SEQ,  1, OKAY, 2'b01, 0, 0, "burst_seq3");
    step(1, 2'b11, SEQ,  1, OKAY, 2'b01, 0, 0, "burst_seq_at_limit");
    step(1, 2'b11, NSEQ, 1, OKAY, 2'b10, 1, 0, "hold_limit_switch");
    // hready low freezes everything while requests change
    step(1, 2'b01, IDLE, 0, OKAY, 2'b10, 1, 0, "wait_1");
    step(1, 2'b00, IDLE, 0, OKAY, 2'b10, 1, 0, "wait_2");
    step(1, 2'b11, BUSY, 0, OKAY, 2'b10, 1, 0, "wait_3");
    step(1, 2'b01, IDLE, 1, OKAY, 2'b01, 0, 1, "wait_release");
    // Owner drops request during SEQ while M1 raises it
    step(1, 2'b01, NSEQ, 1, OKAY, 2'b01, 0, 0, "m0_owns");
    step(1, 2'b10, SEQ,  1, OKAY, 2'b10, 1, 0, "drop_handover");
    // No requests: park on default, then default master claims the bus
    step(1, 2'b00, IDLE, 1, OKAY, 2'b01, 0, 1, "to_park");
    step(1, 2'b00, IDLE, 1, OKAY, 2'b01, 0, 0, "parked");
    step(1, 2'b01, IDLE, 1, OKAY, 2'b01, 0, 0, "default_owns");
    // ERROR does not force re-arbitration
    step(1, 2'b11, SEQ,  1, ERR,  2'b01, 0, 0, "error_no_switch");
    // Reset mid-transfer drops ownership
    step(1, 2'b10, IDLE, 1, OKAY, 2'b10, 1, 0, "grant_m1_again");
    step(0, 2'b10, NSEQ, 1, OKAY, 2'b01, 0, 0, "reset_mid_xfer");
    step(1, 2'b10, IDLE, 1, OKAY, 2'b10, 1, 0, "regrant_after_reset");
`ifdef ARB_HLOCK_EN
    step(1, 2'b01, IDLE, 1, OKAY, 2'b01, 0, 1, "lock_setup");
    @(negedge hclk); hlock = 2'b01;
    exp_q.push_back({2'b01, 1'b0, 1'b0}); name_q.push_back("lock_hold0");
    hbusreq = 2'b11; htrans = NSEQ; hready = 1'b1; hresp = OKAY;
    for (int i = 0; i < 6; i++) step(1, 2'b11, NSEQ, 1, OKAY, 2'b01, 0, 0, "locked_keep");
    n_cmp++;
    if (hmastlock !== 1'b1) begin
      n_bad++;
      $display("FAIL hmastlock: got %b want 1", hmastlock);
    end
    @(negedge hclk); hlock = 2'b00;
    exp_q.push_back({2'b10, 1'b1, 1'b0}); name_q.push_back("unlock_switch");
`endif
    repeat (3) @(posedge hclk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
